// File: rtl/fifo_mover_pkg.sv
// Shared types and width helpers for the FWFT packet mover.
package fifo_mover_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        XFER,
        GAP,
        FIN
    } state_t;

    // Pace counter must hold PACE-1; keep at least one bit when PACE is 0.
    function automatic int pace_cnt_w(input int pace);
        return (pace < 1) ? 1 : $clog2(pace + 1);
    endfunction

endpackage

// File: rtl/pace_counter.sv
// Loadable down-counter that stops at zero; times the idle gap between beats.
module pace_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_packet_mover.sv
// Moves length-prefixed packets from a source FWFT data/length FIFO pair to a destination pair.
module fifo_packet_mover
    import fifo_mover_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int LEN_W        = 8,
    parameter int PACE         = 0,
    parameter int AUTO_RESTART = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              len_empty,
    output logic              len_rd_en,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_empty,
    output logic              src_rd_en,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wr_en,
    input  logic              dst_afull,
    output logic [LEN_W-1:0]  dst_len,
    output logic              dst_len_wr_en,
    input  logic              dst_len_full,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              zero_len,
    output logic [LEN_W-1:0]  beats_left
);

    localparam int PCW = pace_cnt_w(PACE);
    localparam logic [PCW-1:0] GAP_LOAD = (PACE > 0) ? PCW'(PACE - 1) : '0;

    state_t state, state_nxt;
    logic   hdr_fire;
    logic   beat;
    logic   last_beat;
    logic   abort;
    logic   gap_load;
    logic   gap_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop masks every pop so unread beats stay in the source FIFO.
    always_comb begin
        state_nxt = state;
        hdr_fire  = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        abort     = 1'b0;
        gap_load  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (stop) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (!len_empty && !dst_len_full) begin
                    hdr_fire = 1'b1;
                    if (len_in != '0) begin
                        state_nxt = XFER;
                    end else if (AUTO_RESTART == 0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            XFER: begin
                if (stop) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (!src_empty && !dst_afull) begin
                    beat      = 1'b1;
                    last_beat = (beats_left == LEN_W'(1));
                    if (last_beat) begin
                        state_nxt = FIN;
                    end else if (PACE > 0) begin
                        gap_load  = 1'b1;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (gap_zero) begin
                    state_nxt = XFER;
                end
            end
            FIN: begin
                state_nxt = (AUTO_RESTART != 0 || start) ? HDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign len_rd_en = hdr_fire;
    assign src_rd_en = beat;
    assign busy      = (state != IDLE);

    pace_counter #(
        .W(PCW)
    ) u_pace (
        .clk     (clk),
        .reset   (reset),
        .load    (gap_load),
        .load_val(GAP_LOAD),
        .zero    (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_data      <= '0;
            dst_wr_en     <= 1'b0;
            dst_len       <= '0;
            dst_len_wr_en <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            zero_len      <= 1'b0;
            beats_left    <= '0;
        end else begin
            dst_wr_en     <= beat;
            dst_len_wr_en <= hdr_fire && (len_in != '0);
            zero_len      <= hdr_fire && (len_in == '0);
            done          <= (state == FIN);
            aborted       <= abort;
            if (beat) begin
                dst_data <= src_data;
            end
            if (hdr_fire && (len_in != '0)) begin
                dst_len <= len_in;
            end
            // beats_left saturates at zero rather than wrapping.
            if (abort) begin
                beats_left <= '0;
            end else if (hdr_fire && (len_in != '0)) begin
                beats_left <= len_in;
            end else if (beat && (beats_left != '0)) begin
                beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_packet_mover.sv
// Scoreboard bench: instance 0 runs PACE=0/no restart, instance 1 runs PACE=1/auto-restart.
module tb_fifo_packet_mover;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop, dst_afull, dst_len_full, flush;
    logic [7:0] len_in [2], src_data [2], dst_data [2], dst_len [2], beats_left [2];
    logic len_empty [2], len_rd_en [2], src_empty [2], src_rd_en [2];
    logic dst_wr_en [2], dst_len_wr_en [2], busy [2], done [2], aborted [2], zero_len [2];

    // Behavioural FWFT source FIFOs, one data and one length FIFO per instance.
    logic [7:0] dmem [2][64];
    logic [7:0] lmem [2][64];
    logic [5:0] dwr [2] = '{default: '0};
    logic [5:0] drd [2] = '{default: '0};
    logic [5:0] lwr [2] = '{default: '0};
    logic [5:0] lrd [2] = '{default: '0};

    logic [7:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 2; g++) begin : g_src
        assign src_data[g]  = dmem[g][drd[g]];
        assign src_empty[g] = (drd[g] == dwr[g]);
        assign len_in[g]    = lmem[g][lrd[g]];
        assign len_empty[g] = (lrd[g] == lwr[g]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                drd[i] <= dwr[i];
                lrd[i] <= lwr[i];
            end else begin
                if (src_rd_en[i]) drd[i] <= drd[i] + 6'd1;
                if (len_rd_en[i]) lrd[i] <= lrd[i] + 6'd1;
            end
        end
    end

    fifo_packet_mover #(.DATA_W(8), .LEN_W(8), .PACE(0), .AUTO_RESTART(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .len_in(len_in[0]), .len_empty(len_empty[0]), .len_rd_en(len_rd_en[0]),
        .src_data(src_data[0]), .src_empty(src_empty[0]), .src_rd_en(src_rd_en[0]),
        .dst_data(dst_data[0]), .dst_wr_en(dst_wr_en[0]), .dst_afull(dst_afull),
        .dst_len(dst_len[0]), .dst_len_wr_en(dst_len_wr_en[0]), .dst_len_full(dst_len_full),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .zero_len(zero_len[0]),
        .beats_left(beats_left[0])
    );

    fifo_packet_mover #(.DATA_W(8), .LEN_W(8), .PACE(1), .AUTO_RESTART(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .len_in(len_in[1]), .len_empty(len_empty[1]), .len_rd_en(len_rd_en[1]),
        .src_data(src_data[1]), .src_empty(src_empty[1]), .src_rd_en(src_rd_en[1]),
        .dst_data(dst_data[1]), .dst_wr_en(dst_wr_en[1]), .dst_afull(dst_afull),
        .dst_len(dst_len[1]), .dst_len_wr_en(dst_len_wr_en[1]), .dst_len_full(dst_len_full),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .zero_len(zero_len[1]),
        .beats_left(beats_left[1])
    );

    task automatic push_len(input int i, input logic [7:0] l);
        lmem[i][lwr[i]] = l;
        lwr[i] = lwr[i] + 6'd1;
    endtask

    task automatic push_data(input int i, input logic [7:0] d, input bit expect_out);
        dmem[i][dwr[i]] = d;
        dwr[i] = dwr[i] + 6'd1;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b1;
        start = 1'b0; stop = 1'b0; dst_afull = 1'b0; dst_len_full = 1'b0;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({dst_data[i], dst_wr_en[i], dst_len[i], dst_len_wr_en[i], busy[i], done[i],
                 aborted[i], zero_len[i], beats_left[i]} !== 30'd0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d got data=%h wr=%b len=%h lwr=%b busy=%b done=%b ab=%b zl=%b bl=%h exp all zero",
                         i, dst_data[i], dst_wr_en[i], dst_len[i], dst_len_wr_en[i], busy[i],
                         done[i], aborted[i], zero_len[i], beats_left[i]);
            end
        end
    endtask

    task automatic test_basic();
        int wr_cyc [$];
        int lenw = 0;
        int done_cyc = -1;
        logic [7:0] e;
        do_reset();
        push_len(0, 8'd4);
        for (int k = 0; k < 4; k++) push_data(0, 8'(8'hA0 + k), 1'b1);
        start = 1'b1; dst_len_full = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[0]) begin
                wr_cyc.push_back(c); tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL basic_data got=%h exp=none", dst_data[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[0] !== e) begin fails++; $display("FAIL basic_data got=%h exp=%h", dst_data[0], e); end
                end
            end
            if (dst_len_wr_en[0]) begin
                lenw++; tests++;
                if (dst_len[0] !== 8'd4) begin fails++; $display("FAIL basic_len got=%h exp=04", dst_len[0]); end
            end
            if (done[0]) done_cyc = c;
            if (c == 3) dst_len_full = 1'b0;
            #1;
            if (dst_len_full) begin
                tests++;
                if (len_rd_en[0] !== 1'b0) begin fails++; $display("FAIL basic_len_full_pop got=%b exp=0", len_rd_en[0]); end
            end
        end
        tests++;
        if (lenw != 1) begin fails++; $display("FAIL basic_len_count got=%0d exp=1", lenw); end
        tests++;
        if (wr_cyc.size() != 4 || wr_cyc[wr_cyc.size()-1] - wr_cyc[0] != 3) begin
            fails++; $display("FAIL basic_consecutive got_writes=%0d exp=4 back-to-back", wr_cyc.size());
        end
        tests++;
        if (wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
            fails++; $display("FAIL basic_done_cycle got=%0d exp=last_write+1", done_cyc);
        end
        tests++;
        if (exp_q.size() != 0 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL basic_drain got_left=%0d busy=%b exp 0/0", exp_q.size(), busy[0]);
        end
    endtask

    task automatic test_pace();
        int wr_cyc [$];
        int nd = 0;
        int nbl = 0;
        logic [31:0] bl_pack = '0;
        logic [7:0] prev = 8'd0;
        logic [7:0] e;
        do_reset();
        push_len(1, 8'd3);
        for (int k = 0; k < 3; k++) push_data(1, 8'(8'hB0 + k), 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[1]) begin
                wr_cyc.push_back(c); tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL pace_data got=%h exp=none", dst_data[1]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[1] !== e) begin fails++; $display("FAIL pace_data got=%h exp=%h", dst_data[1], e); end
                end
            end
            if (beats_left[1] !== prev) begin
                bl_pack = {bl_pack[23:0], beats_left[1]}; nbl++; prev = beats_left[1];
            end
            if (done[1]) nd++;
        end
        tests++;
        if (wr_cyc.size() != 3 || wr_cyc[1] - wr_cyc[0] != 2 || wr_cyc[2] - wr_cyc[1] != 2) begin
            fails++; $display("FAIL pace_pattern got_writes=%0d exp=3 spaced by 2", wr_cyc.size());
        end
        tests++;
        if (nbl != 4 || bl_pack !== 32'h03020100) begin
            fails++; $display("FAIL pace_beats_left got=%h (%0d steps) exp=03020100", bl_pack, nbl);
        end
        tests++;
        if (nd != 1 || exp_q.size() != 0) begin
            fails++; $display("FAIL pace_done got=%0d left=%0d exp=1/0", nd, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int nwr = 0;
        int nd = 0;
        logic [7:0] e;
        do_reset();
        push_len(0, 8'd6);
        for (int k = 0; k < 6; k++) push_data(0, 8'(8'hD0 + k), 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[0]) begin
                nwr++; tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL bp_data got=%h exp=none", dst_data[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[0] !== e) begin fails++; $display("FAIL bp_data got=%h exp=%h", dst_data[0], e); end
                end
            end
            if (done[0]) nd++;
            dst_afull = (c >= 4 && c <= 8);
            #1;
            if (dst_afull) begin
                tests++;
                if (src_rd_en[0] !== 1'b0) begin fails++; $display("FAIL bp_stall_pop got=%b exp=0", src_rd_en[0]); end
            end
        end
        tests++;
        if (nwr != 6 || nd != 1 || exp_q.size() != 0) begin
            fails++; $display("FAIL bp_totals got writes=%0d done=%0d left=%0d exp 6/1/0", nwr, nd, exp_q.size());
        end
    endtask

    task automatic test_auto_restart();
        int nzl = 0;
        int nlw = 0;
        int nd = 0;
        logic [7:0] e;
        do_reset();
        push_len(1, 8'd0);
        push_len(1, 8'd2);
        push_data(1, 8'hC0, 1'b1);
        push_data(1, 8'hC1, 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[1]) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL ar_data got=%h exp=none", dst_data[1]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[1] !== e) begin fails++; $display("FAIL ar_data got=%h exp=%h", dst_data[1], e); end
                end
            end
            if (dst_len_wr_en[1]) begin
                nlw++; tests++;
                if (dst_len[1] !== 8'd2) begin fails++; $display("FAIL ar_len got=%h exp=02", dst_len[1]); end
            end
            if (zero_len[1]) nzl++;
            if (done[1]) nd++;
        end
        tests++;
        if (nzl != 1 || nlw != 1 || nd != 1 || exp_q.size() != 0) begin
            fails++; $display("FAIL ar_totals got zl=%0d lenw=%0d done=%0d left=%0d exp 1/1/1/0", nzl, nlw, nd, exp_q.size());
        end
    endtask

    task automatic test_stop();
        int nwr = 0;
        int nab = 0;
        int nd = 0;
        bit stopped = 1'b0;
        logic [5:0] base;
        logic [5:0] left;
        logic [7:0] e;
        do_reset();
        base = dwr[0];
        push_len(0, 8'd5);
        for (int k = 0; k < 5; k++) push_data(0, 8'(8'hE0 + k), k < 2);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[0]) begin
                nwr++; tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stop_data got=%h exp=none", dst_data[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[0] !== e) begin fails++; $display("FAIL stop_data got=%h exp=%h", dst_data[0], e); end
                end
            end
            if (aborted[0]) begin
                nab++; tests++;
                if (busy[0] !== 1'b0) begin fails++; $display("FAIL stop_busy got=%b exp=0", busy[0]); end
                stop = 1'b0;
            end
            if (done[0]) nd++;
            if (!stopped && (drd[0] - base) == 6'd2) begin
                stop = 1'b1; stopped = 1'b1;
            end
        end
        stop = 1'b0;
        left = dwr[0] - drd[0];
        tests++;
        if (nwr != 2 || nab != 1 || nd != 0) begin
            fails++; $display("FAIL stop_totals got writes=%0d aborted=%0d done=%0d exp 2/1/0", nwr, nab, nd);
        end
        tests++;
        if (left != 6'd3 || beats_left[0] !== 8'd0) begin
            fails++; $display("FAIL stop_leftover got fifo=%0d beats_left=%0d exp 3/0", left, beats_left[0]);
        end
    endtask

    task automatic test_reset_mid();
        int nwr = 0;
        int nab = 0;
        int nd = 0;
        int nlw = 0;
        logic [7:0] e;
        do_reset();
        push_len(0, 8'd3);
        for (int k = 0; k < 3; k++) push_data(0, 8'(8'hF0 + k), 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        reset = 1'b1; flush = 1'b1;
        @(negedge clk);
        tests++;
        if ({dst_data[0], dst_wr_en[0], dst_len[0], dst_len_wr_en[0], busy[0], done[0],
             aborted[0], zero_len[0], beats_left[0]} !== 30'd0) begin
            fails++;
            $display("FAIL midreset_outputs got data=%h wr=%b len=%h busy=%b done=%b ab=%b bl=%h exp all zero",
                     dst_data[0], dst_wr_en[0], dst_len[0], busy[0], done[0], aborted[0], beats_left[0]);
        end
        reset = 1'b0; flush = 1'b0;
        exp_q.delete();
        push_len(0, 8'd1);
        push_data(0, 8'h5A, 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (dst_wr_en[0]) begin
                nwr++; tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL midreset_data got=%h exp=none", dst_data[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_data[0] !== e) begin fails++; $display("FAIL midreset_data got=%h exp=%h", dst_data[0], e); end
                end
            end
            if (dst_len_wr_en[0]) begin
                nlw++; tests++;
                if (dst_len[0] !== 8'd1) begin fails++; $display("FAIL midreset_len got=%h exp=01", dst_len[0]); end
            end
            if (aborted[0]) nab++;
            if (done[0]) nd++;
        end
        tests++;
        if (nwr != 1 || nlw != 1 || nd != 1 || nab != 0 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL midreset_totals got writes=%0d lenw=%0d done=%0d ab=%0d busy=%b exp 1/1/1/0/0",
                              nwr, nlw, nd, nab, busy[0]);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b1;
        start = 1'b0; stop = 1'b0; dst_afull = 1'b0; dst_len_full = 1'b0;
        test_reset();
        test_basic();
        test_pace();
        test_backpressure();
        test_auto_restart();
        test_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
